vga_layer_mixer: RTL and testbench

VGA_LAYER_MIXER -- requirements
Module: vga_layer_mixer

---
 rtl/mixer_pkg.sv | 27 ++
 rtl/sync_delay_line.sv | 28 ++
 rtl/vga_layer_mixer.sv | 161 ++++++++++++++++
 tb/tb_vga_layer_mixer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared definitions for the VGA layer mixer: RGB565 field map, transparency key,
// flash-state encoding and the saturating brighten helper.
package mixer_pkg;

  localparam logic [15:0] TRANSPARENT_KEY = 16'hFFF0;

  localparam int R_MSB = 15;
  localparam int R_LSB = 12;
  localparam int G_MSB = 10;
  localparam int G_LSB = 7;
  localparam int B_MSB = 4;
  localparam int B_LSB = 1;

  localparam logic [3:0] FLASH_BOOST = 4'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_e;

  function automatic logic [3:0] boost_chan(input logic [3:0] chan);
    logic [4:0] sum;
    sum = {1'b0, chan} + {1'b0, FLASH_BOOST};
    return sum[4] ? 4'hF : sum[3:0];
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register used to delay the timing-generator syncs and the
// active flag; each bit has its own reset value so syncs can idle high.
module sync_delay_line #(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pixel_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else if (pixel_en_i) begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_layer_mixer.sv
// Priority mixer of RGB565 layers onto a 4:4:4 VGA DAC with matched sync delay.
// Optional hit-flash effect (IDLE/FLASH FSM) is built only with MIXER_HIT_FLASH_EN.
module vga_layer_mixer
  import mixer_pkg::*;
#(
  parameter int          NUM_LAYERS      = 4,
  parameter int          PIPE_DELAY      = 2,
  parameter logic [15:0] TRANSPARENT_KEY = mixer_pkg::TRANSPARENT_KEY,
  parameter logic [15:0] BG_COLOR        = 16'h0000,
  parameter int          FLASH_FRAMES    = 8
) (
  input  logic                    OriginalClk,
  input  logic                    Reset,
  input  logic                    PixelEn,
  input  logic                    HSyncIn,
  input  logic                    VSyncIn,
  input  logic                    ActiveIn,
  input  logic [NUM_LAYERS*16-1:0] LayerData,
  input  logic                    HitFlash,
  output logic [3:0]              VgaR,
  output logic [3:0]              VgaG,
  output logic [3:0]              VgaB,
  output logic                    HSyncOut,
  output logic                    VSyncOut,
  output logic                    FrameStart,
  output logic [7:0]              FrameCount
);

  // The line covers PIPE_DELAY stages (aligned with LayerData); the output
  // register below supplies the final stage, shared with the colour register.
  logic hs_dly, vs_dly, act_dly;

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (3'b110)
  ) u_sync_delay (
    .clk_i      (OriginalClk),
    .rst_i      (Reset),
    .pixel_en_i (PixelEn),
    .data_i     ({HSyncIn, VSyncIn, ActiveIn}),
    .data_o     ({hs_dly, vs_dly, act_dly})
  );

  logic [15:0] pix_d;

  always_comb begin
    pix_d = BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (LayerData[16*k +: 16] != TRANSPARENT_KEY) pix_d = LayerData[16*k +: 16];
    end
  end

  logic       flash_on;
  logic [3:0] r_d, g_d, b_d;

  always_comb begin
    r_d = 4'h0;
    g_d = 4'h0;
    b_d = 4'h0;
    if (act_dly) begin
      r_d = pix_d[R_MSB:R_LSB];
      g_d = pix_d[G_MSB:G_LSB];
      b_d = pix_d[B_MSB:B_LSB];
      if (flash_on) begin
        r_d = boost_chan(pix_d[R_MSB:R_LSB]);
        g_d = boost_chan(pix_d[G_MSB:G_LSB]);
        b_d = boost_chan(pix_d[B_MSB:B_LSB]);
      end
    end
  end

  logic       frame_fall;
  logic [3:0] r_q, g_q, b_q;
  logic       hs_q, vs_q, fs_q;
  logic [7:0] fc_q;

  assign frame_fall = PixelEn && vs_q && !vs_dly;

  // FrameStart clears on every clock so it stays one OriginalClk wide even
  // when PixelEn drops right after the VSync fall.
  always_ff @(posedge OriginalClk) begin
    if (Reset) begin
      r_q  <= 4'h0;
      g_q  <= 4'h0;
      b_q  <= 4'h0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fs_q <= 1'b0;
      fc_q <= 8'd0;
    end else begin
      fs_q <= frame_fall;
      if (PixelEn) begin
        r_q  <= r_d;
        g_q  <= g_d;
        b_q  <= b_d;
        hs_q <= hs_dly;
        vs_q <= vs_dly;
        if (frame_fall) fc_q <= fc_q + 8'd1;
      end
    end
  end

`ifdef MIXER_HIT_FLASH_EN
  localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

  flash_state_e state_q;
  logic [7:0]   frames_left_q;

  // A new hit always reloads, including on the frame that would expire the flash.
  always_ff @(posedge OriginalClk) begin
    if (Reset) begin
      state_q       <= IDLE;
      frames_left_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (HitFlash) begin
            state_q       <= FLASH;
            frames_left_q <= FLASH_LOAD;
          end
        end
        FLASH: begin
          if (HitFlash) begin
            frames_left_q <= FLASH_LOAD;
          end else if (frame_fall) begin
            if (frames_left_q == 8'd1) begin
              state_q       <= IDLE;
              frames_left_q <= 8'd0;
            end else begin
              frames_left_q <= frames_left_q - 8'd1;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          frames_left_q <= 8'd0;
        end
      endcase
    end
  end

  assign flash_on = (state_q == FLASH);
`else
  logic unused_hit_flash;
  assign unused_hit_flash = HitFlash;
  assign flash_on = 1'b0;
`endif

  logic [3:0] unused_pix_bits;
  assign unused_pix_bits = {pix_d[11], pix_d[6:5], pix_d[0]};

  assign VgaR       = r_q;
  assign VgaG       = g_q;
  assign VgaB       = b_q;
  assign HSyncOut   = hs_q;
  assign VSyncOut   = vs_q;
  assign FrameStart = fs_q;
  assign FrameCount = fc_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Directed bench for vga_layer_mixer (default parameters); the flash section
// runs when MIXER_HIT_FLASH_EN is defined, otherwise HitFlash must be ignored.
module tb_vga_layer_mixer;

  localparam int NL = 4;

  logic            OriginalClk = 1'b0;
  logic            Reset, PixelEn, HSyncIn, VSyncIn, ActiveIn, HitFlash;
  logic [NL*16-1:0] LayerData;
  logic [3:0]      VgaR, VgaG, VgaB;
  logic            HSyncOut, VSyncOut, FrameStart;
  logic [7:0]      FrameCount;

  int vectors     = 0;
  int miscompares = 0;
  int fs_seen     = 0;

  always #5 OriginalClk = ~OriginalClk;

  vga_layer_mixer dut (
    .OriginalClk (OriginalClk),
    .Reset       (Reset),
    .PixelEn     (PixelEn),
    .HSyncIn     (HSyncIn),
    .VSyncIn     (VSyncIn),
    .ActiveIn    (ActiveIn),
    .LayerData   (LayerData),
    .HitFlash    (HitFlash),
    .VgaR        (VgaR),
    .VgaG        (VgaG),
    .VgaB        (VgaB),
    .HSyncOut    (HSyncOut),
    .VSyncOut    (VSyncOut),
    .FrameStart  (FrameStart),
    .FrameCount  (FrameCount)
  );

  task automatic tick();
    @(posedge OriginalClk);
    #1;
    if (FrameStart) fs_seen++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    chk(tag, {4'h0, VgaR, VgaG, VgaB}, {4'h0, exp});
  endtask

  task automatic set_layers(input logic [15:0] l0, l1, l2, l3);
    LayerData = {l3, l2, l1, l0};
  endtask

  // The fall is detected on the third edge after VSyncIn drops; hit lines up with it.
  task automatic frame(input logic hit);
    VSyncIn = 1'b0;
    tick();
    tick();
    HitFlash = hit;
    tick();
    HitFlash = 1'b0;
    VSyncIn  = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    Reset    = 1'b1;
    PixelEn  = 1'b1;
    HSyncIn  = 1'b0;
    VSyncIn  = 1'b0;
    ActiveIn = 1'b1;
    HitFlash = 1'b0;
    set_layers(16'hF800, 16'hF800, 16'hF800, 16'hF800);
    repeat (3) tick();
    chk_rgb("rst_rgb", 12'h000);
    chk("rst_hs", {15'd0, HSyncOut}, 16'd1);
    chk("rst_vs", {15'd0, VSyncOut}, 16'd1);
    chk("rst_fc", {8'd0, FrameCount}, 16'd0);
    chk("rst_fs", {15'd0, FrameStart}, 16'd0);

    Reset    = 1'b0;
    HSyncIn  = 1'b1;
    VSyncIn  = 1'b1;
    ActiveIn = 1'b0;
    set_layers(16'hFFF0, 16'hF800, 16'h07E0, 16'h001F);
    repeat (3) tick();
    chk_rgb("blank", 12'h000);

    ActiveIn = 1'b1;
    HSyncIn  = 1'b0;
    tick();
    tick();
    chk_rgb("prio_early", 12'h000);
    chk("hs_early", {15'd0, HSyncOut}, 16'd1);
    tick();
    chk_rgb("prio", 12'hF00);
    chk("hs_align", {15'd0, HSyncOut}, 16'd0);
    HSyncIn = 1'b1;

    set_layers(16'hFFF0, 16'hFFF0, 16'h07E0, 16'h001F);
    tick();
    chk_rgb("prio_l2", 12'h0F0);
    set_layers(16'hFFF0, 16'hFFF0, 16'hFFF0, 16'h001F);
    tick();
    chk_rgb("prio_l3", 12'h00F);
    set_layers(16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFFF0);
    tick();
    chk_rgb("all_transp", 12'h000);
    set_layers(16'hFFF1, 16'hFFF0, 16'hFFF0, 16'hFFF0);
    tick();
    chk_rgb("near_key", 12'hFF8);

    set_layers(16'h8410, 16'hF800, 16'hF800, 16'hF800);
    tick();
    tick();
    chk_rgb("pre_freeze", 12'h888);
    PixelEn  = 1'b0;
    ActiveIn = 1'b0;
    HSyncIn  = 1'b0;
    VSyncIn  = 1'b0;
    set_layers(16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_rgb("freeze_rgb", 12'h888);
      chk("freeze_sync", {14'd0, HSyncOut, VSyncOut}, 16'd3);
      chk("freeze_fc", {8'd0, FrameCount}, 16'd0);
    end
    PixelEn  = 1'b1;
    ActiveIn = 1'b1;
    HSyncIn  = 1'b1;
    VSyncIn  = 1'b1;
    set_layers(16'h8410, 16'hF800, 16'hF800, 16'hF800);
    repeat (3) tick();

    ActiveIn = 1'b0;
    tick();
    ActiveIn = 1'b1;
    tick();
    chk_rgb("blank_wait", 12'h888);
    tick();
    chk_rgb("blank_pulse", 12'h000);
    tick();
    chk_rgb("unblank", 12'h888);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (3) tick();
    fs_seen = 0;
    repeat (257) frame(1'b0);
    tick();
    tick();
    chk("fs_pulses", 16'(fs_seen), 16'd257);
    chk("fc_wrap", {8'd0, FrameCount}, 16'd1);

    VSyncIn = 1'b0;
    tick();
    tick();
    tick();
    chk("fs_hi", {15'd0, FrameStart}, 16'd1);
    PixelEn = 1'b0;
    tick();
    chk("fs_single", {15'd0, FrameStart}, 16'd0);
    chk("fc_inc", {8'd0, FrameCount}, 16'd2);
    PixelEn = 1'b1;
    VSyncIn = 1'b1;
    repeat (3) tick();

    HSyncIn = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    chk_rgb("midrst_rgb", 12'h000);
    chk("midrst_hs", {15'd0, HSyncOut}, 16'd1);
    chk("midrst_fc", {8'd0, FrameCount}, 16'd0);
    Reset   = 1'b0;
    HSyncIn = 1'b1;
    repeat (3) tick();
    chk_rgb("post_rst", 12'h888);

`ifdef MIXER_HIT_FLASH_EN
    HitFlash = 1'b1;
    PixelEn  = 1'b0;
    tick();
    HitFlash = 1'b0;
    PixelEn  = 1'b1;
    tick();
    chk_rgb("flash_on", 12'hCCC);
    for (int i = 0; i < 7; i++) begin
      frame(1'b0);
      chk_rgb("flash_frame", 12'hCCC);
    end
    frame(1'b0);
    chk_rgb("flash_end", 12'h888);

    HitFlash = 1'b1;
    tick();
    HitFlash = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      frame(1'b0);
      chk_rgb("retrig_pre", 12'hCCC);
    end
    HitFlash = 1'b1;
    tick();
    HitFlash = 1'b0;
    for (int i = 0; i < 7; i++) begin
      frame(1'b0);
      chk_rgb("retrig_frame", 12'hCCC);
    end
    frame(1'b0);
    chk_rgb("retrig_end", 12'h888);

    HitFlash = 1'b1;
    tick();
    HitFlash = 1'b0;
    for (int i = 0; i < 7; i++) frame(1'b0);
    frame(1'b1);
    chk_rgb("coinc_hold", 12'hCCC);
    for (int i = 0; i < 7; i++) begin
      frame(1'b0);
      chk_rgb("coinc_frame", 12'hCCC);
    end
    frame(1'b0);
    chk_rgb("coinc_end", 12'h888);

    HitFlash = 1'b1;
    set_layers(16'hF7DE, 16'hF800, 16'hF800, 16'hF800);
    tick();
    HitFlash = 1'b0;
    tick();
    chk_rgb("flash_sat", 12'hFFF);
    set_layers(16'h07E0, 16'hF800, 16'hF800, 16'hF800);
    tick();
    chk_rgb("flash_sat_g", 12'h4F4);
    ActiveIn = 1'b0;
    repeat (3) tick();
    chk_rgb("flash_blank", 12'h000);
    ActiveIn = 1'b1;
    set_layers(16'h8410, 16'hF800, 16'hF800, 16'hF800);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    repeat (3) tick();
    chk_rgb("flash_rst", 12'h888);
`else
    HitFlash = 1'b1;
    tick();
    HitFlash = 1'b0;
    tick();
    tick();
    chk_rgb("hit_ignored", 12'h888);
    frame(1'b0);
    chk_rgb("hit_ignored_frame", 12'h888);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
